// File: rtl/tile_line_prefetch.sv
// tile_line_prefetch: fetches one display line as 128-bit bursts from the
// SDRAM P1 burst port into a double-buffered line store. While that fetch runs,
// it serves 8-bit pixels from the other bank. Lines that do not finish
// fetching before the next LineStart set a sticky Underrun flag.
module tile_line_prefetch #(
    parameter int LINE_BURSTS = 40
) (
    input  logic         SlowMemClk,
    input  logic         Reset,
    input  logic         LineStart,
    input  logic [18:0]  LineBase,
    output logic         P1_Req,
    output logic [18:0]  P1_Address,
    input  logic         P1_Ack,
    input  logic [127:0] P1_DataRead,
    input  logic         PixelEn,
    output logic [7:0]   Pixel,
    output logic         LineReady,
    output logic         Underrun
);

    localparam int PIX_MAX_I = LINE_BURSTS * 16;
    localparam int PIX_W     = $clog2(PIX_MAX_I + 1);
    localparam int BI_W      = (LINE_BURSTS > 1) ? $clog2(LINE_BURSTS) : 1;

    localparam logic [PIX_W-1:0] PIX_MAX    = PIX_W'(PIX_MAX_I);
    localparam logic [PIX_W-1:0] PIX_ONE    = PIX_W'(1);
    localparam logic [BI_W-1:0]  LAST_BURST = BI_W'(LINE_BURSTS - 1);
    localparam logic [BI_W-1:0]  BI_ONE     = BI_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              bank_sel_q, bank_sel_d;
    logic [PIX_W-1:0]  pix_idx_q, pix_idx_d;
    logic [BI_W-1:0]   burst_idx_q, burst_idx_d;
    logic [18:0]       addr_q, addr_d;
    logic              req_q, req_d;
    logic              ready_q, ready_d;
    logic              underrun_q, underrun_d;
    logic [7:0]        pixel_q, pixel_d;

    logic              wr_en_s;
    logic              wr_bank_s;
    logic [BI_W-1:0]   wr_idx_s;
    logic [BI_W-1:0]   entry_s;
    logic [3:0]        byte_sel_s;
    logic [127:0]      word_s;

    // Line store: bank 0/1, one 128-bit burst per entry; never cleared by reset.
    logic [127:0] mem_q [0:1][0:LINE_BURSTS-1];

    // Next-state logic: LineStart has priority over Ack and PixelEn.
    always_comb begin
        state_d     = state_q;
        bank_sel_d  = bank_sel_q;
        pix_idx_d   = pix_idx_q;
        burst_idx_d = burst_idx_q;
        addr_d      = addr_q;
        req_d       = req_q;
        ready_d     = ready_q;
        underrun_d  = underrun_q;
        wr_en_s     = 1'b0;
        wr_bank_s   = ~bank_sel_q;
        wr_idx_s    = burst_idx_q;

        if (LineStart) begin
            // A LineStart that finds a fetch still running abandons it.
            if (state_q == FETCH) begin
                underrun_d = 1'b1;
            end else begin
                underrun_d = underrun_q;
            end
            bank_sel_d  = ~bank_sel_q;
            pix_idx_d   = {PIX_W{1'b0}};
            burst_idx_d = {BI_W{1'b0}};
            addr_d      = LineBase;
            req_d       = 1'b1;
            ready_d     = 1'b0;
            state_d     = FETCH;
        end else begin
            if (PixelEn && (pix_idx_q != PIX_MAX)) begin
                pix_idx_d = pix_idx_q + PIX_ONE;
            end else begin
                pix_idx_d = pix_idx_q;
            end

            case (state_q)
                FETCH: begin
                    if (P1_Ack) begin
                        wr_en_s = 1'b1;
                        addr_d  = addr_q + 19'd1;
                        if (burst_idx_q == LAST_BURST) begin
                            req_d   = 1'b0;
                            ready_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            burst_idx_d = burst_idx_q + BI_ONE;
                        end
                    end else begin
                        state_d = FETCH;
                    end
                end
                IDLE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Pixel select: high byte of the first SDRAM word comes out first; blank past line end.
    always_comb begin
        entry_s    = {BI_W{1'b0}};
        byte_sel_s = 4'd15 - pix_idx_q[3:0];
        word_s     = 128'd0;
        pixel_d    = 8'h00;
        if (pix_idx_q >= PIX_MAX) begin
            pixel_d = 8'h00;
        end else begin
            entry_s = BI_W'(pix_idx_q >> 4);
            word_s  = mem_q[bank_sel_q][entry_s];
            pixel_d = word_s[{byte_sel_s, 3'b000} +: 8];
        end
    end

    // Control and output registers with asynchronous active-low reset.
    always_ff @(posedge SlowMemClk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            bank_sel_q  <= 1'b0;
            pix_idx_q   <= PIX_MAX;
            burst_idx_q <= {BI_W{1'b0}};
            addr_q      <= 19'd0;
            req_q       <= 1'b0;
            ready_q     <= 1'b0;
            underrun_q  <= 1'b0;
            pixel_q     <= 8'h00;
        end else begin
            state_q     <= state_d;
            bank_sel_q  <= bank_sel_d;
            pix_idx_q   <= pix_idx_d;
            burst_idx_q <= burst_idx_d;
            addr_q      <= addr_d;
            req_q       <= req_d;
            ready_q     <= ready_d;
            underrun_q  <= underrun_d;
            pixel_q     <= pixel_d;
        end
    end

    // Burst capture into the fetch bank; contents survive reset.
    always_ff @(posedge SlowMemClk) begin
        if (wr_en_s) begin
            mem_q[wr_bank_s][wr_idx_s] <= P1_DataRead;
        end
    end

    assign P1_Req     = req_q;
    assign P1_Address = addr_q;
    assign LineReady  = ready_q;
    assign Underrun   = underrun_q;
    assign Pixel      = pixel_q;

endmodule

// File: tb/tb_tile_line_prefetch.sv
// Self-checking bench for tile_line_prefetch: directed line fetches plus
// randomized traffic, compared each cycle against a behavioural line-buffer model.
module tb_tile_line_prefetch;

    localparam int LB      = 40;
    localparam int PIX_MAX = LB * 16;

    logic         SlowMemClk = 1'b0;
    logic         Reset      = 1'b0;
    logic         LineStart  = 1'b0;
    logic [18:0]  LineBase   = 19'd0;
    logic         P1_Ack     = 1'b0;
    logic [127:0] P1_DataRead = 128'd0;
    logic         PixelEn    = 1'b0;
    logic         P1_Req;
    logic [18:0]  P1_Address;
    logic [7:0]   Pixel;
    logic         LineReady;
    logic         Underrun;

    tile_line_prefetch #(.LINE_BURSTS(LB)) dut (
        .SlowMemClk (SlowMemClk),
        .Reset      (Reset),
        .LineStart  (LineStart),
        .LineBase   (LineBase),
        .P1_Req     (P1_Req),
        .P1_Address (P1_Address),
        .P1_Ack     (P1_Ack),
        .P1_DataRead(P1_DataRead),
        .PixelEn    (PixelEn),
        .Pixel      (Pixel),
        .LineReady  (LineReady),
        .Underrun   (Underrun)
    );

    initial forever #5 SlowMemClk = ~SlowMemClk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [127:0] m_mem [0:1][0:LB-1];
    bit           m_vld [0:1][0:LB-1];
    bit           m_req, m_ready, m_under, m_known;
    int           m_bank, m_pix, m_cnt;
    logic [18:0]  m_addr;
    logic [7:0]   m_pixel;

    function automatic logic [7:0] pix_byte(input int b, input int p);
        logic [127:0] w;
        w = m_mem[b][p / 16];
        return 8'(w >> ((15 - (p % 16)) * 8));
    endfunction

    task automatic model_reset();
        m_req = 0; m_ready = 0; m_under = 0; m_known = 1;
        m_bank = 0; m_pix = PIX_MAX; m_cnt = 0;
        m_addr = 19'd0; m_pixel = 8'h00;
    endtask

    task automatic model_step();
        logic [7:0] nxt_pixel;
        bit         nxt_known;
        if (m_pix >= PIX_MAX) begin
            nxt_pixel = 8'h00;
            nxt_known = 1;
        end else begin
            nxt_known = m_vld[m_bank][m_pix / 16];
            nxt_pixel = pix_byte(m_bank, m_pix);
        end
        if (LineStart) begin
            if (m_req) m_under = 1;
            m_bank  = 1 - m_bank;
            m_pix   = 0;
            m_cnt   = 0;
            m_addr  = LineBase;
            m_req   = 1;
            m_ready = 0;
        end else begin
            if (PixelEn && m_pix < PIX_MAX) m_pix++;
            if (m_req && P1_Ack) begin
                m_mem[1 - m_bank][m_cnt] = P1_DataRead;
                m_vld[1 - m_bank][m_cnt] = 1;
                m_addr = m_addr + 19'd1;
                if (m_cnt == LB - 1) begin
                    m_req   = 0;
                    m_ready = 1;
                end else begin
                    m_cnt++;
                end
            end
        end
        m_pixel = nxt_pixel;
        m_known = nxt_known;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge SlowMemClk or negedge Reset);
            if (!Reset) model_reset();
            else        model_step();
        end
    end

    // Compare process: every output, every cycle, on the falling edge.
    initial forever begin
        @(negedge SlowMemClk);
        check("p1_req",    {31'd0, P1_Req},    {31'd0, m_req});
        check("p1_address", {13'd0, P1_Address}, {13'd0, m_addr});
        check("line_ready", {31'd0, LineReady}, {31'd0, m_ready});
        check("underrun",  {31'd0, Underrun},  {31'd0, m_under});
        if (m_known) check("pixel", {24'd0, Pixel}, {24'd0, m_pixel});
    end

    // Pixel capture log for the literal pins.
    logic [7:0] pix_log [0:1023];
    int         cap_n  = 0;
    bit         cap_on = 0;
    initial forever begin
        @(negedge SlowMemClk);
        if (cap_on && cap_n < 1024) begin
            pix_log[cap_n] = Pixel;
            cap_n++;
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [18:0] addr_log [0:63];

    task automatic tick();
        @(posedge SlowMemClk);
        #2;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] burst_data(input int k);
        logic [127:0] d;
        for (int i = 0; i < 8; i++) d[127 - 16 * i -: 16] = {8'(k), 8'(8'hA0 + i)};
        return d;
    endfunction

    task automatic pulse_line(input logic [18:0] base);
        LineStart = 1'b1;
        LineBase  = base;
        P1_Ack    = 1'b0;
        tick();
        LineStart = 1'b0;
        LineBase  = 19'($urandom);
    endtask

    task automatic ack_bursts(input int n, input bit pat, input logic [18:0] base);
        int given = 0;
        int guard = 0;
        while (given < n && guard < 600) begin
            guard++;
            if (P1_Req && ($urandom % 4 != 0)) begin
                P1_Ack      = 1'b1;
                P1_DataRead = pat ? burst_data(given) : rnd128();
                check("addr_seq", {13'd0, P1_Address}, {13'd0, 19'(base + 19'(given))});
                if (given < 64) addr_log[given] = P1_Address;
                given++;
            end else begin
                P1_Ack      = 1'b0;
                P1_DataRead = rnd128();
            end
            tick();
        end
        P1_Ack = 1'b0;
        if (given < n) check("fetch_timeout", given, n);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int guard;
        #23 Reset = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("rst_req",   {31'd0, P1_Req},    32'd0);
        check("rst_pixel", {24'd0, Pixel},     32'd0);
        check("rst_ready", {31'd0, LineReady}, 32'd0);
        check("rst_under", {31'd0, Underrun},  32'd0);
        check("rst_addr",  {13'd0, P1_Address}, 32'd0);

        // Line 1: base 0x100, patterned data.
        pulse_line(19'h00100);
        check("req_after_start", {31'd0, P1_Req}, 32'd1);
        ack_bursts(LB, 1'b1, 19'h00100);
        check("l1_ready",  {31'd0, LineReady}, 32'd1);
        check("l1_req",    {31'd0, P1_Req},    32'd0);
        check("l1_addr0",  {13'd0, addr_log[0]},  32'h00100);
        check("l1_addr39", {13'd0, addr_log[39]}, 32'h00127);

        // Line 2: display line 1 with PixelEn held; fetch with wrapping address.
        PixelEn = 1'b1;
        pulse_line(19'h7FFFE);
        cap_n  = 0;
        cap_on = 1;
        ack_bursts(LB, 1'b0, 19'h7FFFE);
        guard = 0;
        while (cap_n < 660 && guard < 2000) begin
            guard++;
            tick();
        end
        cap_on  = 0;
        PixelEn = 1'b0;
        check("wrap_a0", {13'd0, addr_log[0]}, 32'h7FFFE);
        check("wrap_a1", {13'd0, addr_log[1]}, 32'h7FFFF);
        check("wrap_a2", {13'd0, addr_log[2]}, 32'h00000);
        check("wrap_a3", {13'd0, addr_log[3]}, 32'h00001);
        check("pix_0",   {24'd0, pix_log[1]},   32'h00);
        check("pix_1",   {24'd0, pix_log[2]},   32'hA0);
        check("pix_16",  {24'd0, pix_log[17]},  32'h01);
        check("pix_17",  {24'd0, pix_log[18]},  32'hA0);
        check("pix_31",  {24'd0, pix_log[32]},  32'hA7);
        check("pix_624", {24'd0, pix_log[625]}, 32'h27);
        check("pix_639", {24'd0, pix_log[640]}, 32'hA7);
        check("pix_blank", {24'd0, pix_log[641]}, 32'h00);

        // Underrun: 10 Acks, then LineStart together with an Ack.
        pulse_line(19'h02000);
        ack_bursts(10, 1'b0, 19'h02000);
        LineStart   = 1'b1;
        LineBase    = 19'h05555;
        P1_Ack      = 1'b1;
        P1_DataRead = rnd128();
        tick();
        LineStart = 1'b0;
        P1_Ack    = 1'b0;
        check("ur_set",  {31'd0, Underrun},   32'd1);
        check("ur_addr", {13'd0, P1_Address}, 32'h05555);
        check("ur_req",  {31'd0, P1_Req},     32'd1);
        PixelEn = 1'b1;
        ack_bursts(LB, 1'b0, 19'h05555);
        for (int i = 0; i < 40; i++) tick();
        PixelEn = 1'b0;
        check("ur_sticky", {31'd0, Underrun}, 32'd1);

        // Asynchronous reset mid-fetch.
        pulse_line(19'h03000);
        ack_bursts(5, 1'b0, 19'h03000);
        @(posedge SlowMemClk);
        #3 Reset = 1'b0;
        #1 check("async_rst_req", {31'd0, P1_Req}, 32'd0);
        check("async_rst_under", {31'd0, Underrun}, 32'd0);
        #10 Reset = 1'b1;
        tick();
        PixelEn = 1'b1;
        pulse_line(19'h40000);
        ack_bursts(LB, 1'b1, 19'h40000);
        PixelEn = 1'b0;
        check("post_rst_ready", {31'd0, LineReady}, 32'd1);
        check("post_rst_under", {31'd0, Underrun},  32'd0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            LineStart   = ($urandom % 120 == 0);
            LineBase    = 19'($urandom);
            P1_Ack      = $urandom % 2;
            P1_DataRead = rnd128();
            PixelEn     = ($urandom % 4 != 0);
            tick();
        end
        LineStart = 1'b0;
        P1_Ack    = 1'b0;
        PixelEn   = 1'b0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
